ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: packs a byte stream into 32-bit words for the core RAM,
// then releases the core from reset once the whole image is written.
module ram_loader #(
  parameter int ADDRWIDTH = 10,
  parameter int DEPTH     = 1024
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 core_nreset,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR =
    ADDRWIDTH'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 last_q, last_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic                 cnr_q, cnr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 accept;

  // Next-state, byte packing and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    accept  = s_valid & ready_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = s_data;
          last_d = s_last;
          if (cnt_q == 2'd3 || s_last) begin
            state_d = WRITE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDRWIDTH'(1);
        wdata_d = 32'd0;
        if (last_q) begin
          state_d = DONE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ERR;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: state_d = DONE;
      ERR:  state_d = ERR;
      default: state_d = ERR;
    endcase
    ready_d = (state_d == LOAD);
    we_d    = (state_d == WRITE);
    cnr_d   = (state_d == DONE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  // State and output registers; reset drops everything to idle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      cnr_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      cnr_q   <= cnr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready     = ready_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign core_nreset = cnr_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule
